// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the AVR-style core.
// Owns the data-memory handshake, halt/error status and the retired-instruction counter.
module fetch_exec_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [3:0]       I_i,
    input  logic             zero_flag_i,
    input  logic             mem_ready_i,
    output logic             en_fetch_o,
    output logic             en_decode_o,
    output logic             alu_en_o,
    output logic             imm_sel_o,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             rf_we_o,
    output logic             pc_inc_o,
    output logic             pc_load_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;
    logic              retire;

    logic is_nop, is_alu, is_imm, is_ld, is_st, is_jmp, is_brz, is_hlt;

    assign is_nop = (op_q == 4'b0000);
    assign is_alu = op_q inside {4'b0001, 4'b0010, 4'b0100, 4'b0101};
    assign is_imm = op_q inside {4'b0011, 4'b0110, 4'b0111, 4'b1000, 4'b1110};
    assign is_ld  = (op_q == 4'b1001);
    assign is_st  = (op_q == 4'b1011);
    assign is_jmp = (op_q == 4'b1100);
    assign is_brz = (op_q == 4'b1101);
    assign is_hlt = (op_q == 4'b1111);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        err_d     = err_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE:   if (run_i) state_d = S_FETCH;
            S_FETCH: begin
                op_d    = I_i;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop) begin
                    retire = 1'b1;
                end else if (is_ld || is_st) begin
                    wait_d  = '0;
                    state_d = S_MEM;
                end else if (is_hlt) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu || is_imm) state_d = S_WB;
                else                  retire  = 1'b1;
            end
            // A ready on the timeout edge still completes the access.
            S_MEM: begin
                if (mem_ready_i) begin
                    if (is_ld) state_d = S_WB;
                    else       retire  = 1'b1;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:     retire  = 1'b1;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        // run is only consulted at an instruction boundary.
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run_i ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            err_q     <= err_d;
        end
    end

    assign en_fetch_o  = (state_q == S_FETCH);
    assign pc_inc_o    = (state_q == S_FETCH);
    assign en_decode_o = (state_q == S_DECODE);
    assign alu_en_o    = (state_q == S_EXEC);
    assign imm_sel_o   = ((state_q == S_EXEC) || (state_q == S_WB)) && is_imm;
    assign mem_rd_o    = (state_q == S_MEM) && is_ld;
    assign mem_wr_o    = (state_q == S_MEM) && is_st;
    assign rf_we_o     = (state_q == S_WB);
    assign pc_load_o   = (state_q == S_EXEC) && (is_jmp || (is_brz && zero_flag_i));
    assign halted_o    = (state_q == S_HALT);
    assign mem_err_o   = err_q;
    assign state_o     = state_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl: scoreboard bench for fetch_exec_ctrl; each step carries the inputs
// to drive before an edge and the state/outputs/retire count expected just after it.
module tb_fetch_exec_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 16;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    logic             clk = 1'b0;
    logic             rst, run, zeroFlag, memReady;
    logic [3:0]       instr;
    logic             enFetch, enDecode, aluEn, immSel, memRd, memWr, rfWe;
    logic             pcInc, pcLoad, halted, memErr;
    logic [2:0]       stateOut;
    logic [CNT_W-1:0] retired;
    logic [10:0]      outsVec;

    always #5 clk = ~clk;

    assign outsVec = {enFetch, enDecode, aluEn, immSel, memRd, memWr,
                      rfWe, pcInc, pcLoad, halted, memErr};

    fetch_exec_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .I_i(instr),
        .zero_flag_i(zeroFlag), .mem_ready_i(memReady),
        .en_fetch_o(enFetch), .en_decode_o(enDecode), .alu_en_o(aluEn),
        .imm_sel_o(immSel), .mem_rd_o(memRd), .mem_wr_o(memWr), .rf_we_o(rfWe),
        .pc_inc_o(pcInc), .pc_load_o(pcLoad), .halted_o(halted), .mem_err_o(memErr),
        .state_o(stateOut), .retired_o(retired)
    );

    typedef struct {
        logic             run;
        logic [3:0]       ins;
        logic             mr;
        logic             zf;
        logic [2:0]       st;
        logic [10:0]      outs;
        logic [CNT_W-1:0] ret;
    } step_t;

    step_t            sbq[$];
    int               compared   = 0;
    int               mismatched = 0;
    logic [CNT_W-1:0] expRet;

    // Expected output vector for a state, in the order of outsVec.
    function automatic logic [10:0] outsFor(input logic [2:0] s, input logic imm, input logic ld,
                                            input logic stv, input logic pcl, input logic err);
        logic [10:0] o;
        o = '0;
        case (s)
            FETCH:   begin o[10] = 1'b1; o[3] = 1'b1; end
            DECODE:  o[9] = 1'b1;
            EXEC:    begin o[8] = 1'b1; o[7] = imm; o[2] = pcl; end
            MEM:     begin o[6] = ld; o[5] = stv; end
            WB:      begin o[4] = 1'b1; o[7] = imm; end
            HALT:    o[1] = 1'b1;
            default: o = '0;
        endcase
        o[0] = err;
        return o;
    endfunction

    function automatic void push(input logic r, input logic [3:0] ins, input logic mr,
                                 input logic zf, input logic [2:0] st, input logic [10:0] o);
        step_t s;
        s.run = r; s.ins = ins; s.mr = mr; s.zf = zf; s.st = st; s.outs = o; s.ret = expRet;
        sbq.push_back(s);
    endfunction

    task automatic test_reset();
        step_t cur;
        rst = 1'b1; run = 1'b0; instr = 4'h0; memReady = 1'b0; zeroFlag = 1'b0; expRet = '0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (stateOut !== IDLE) begin mismatched++; $display("[TB] FAIL reset state: got %0d want %0d", stateOut, IDLE); end
        compared++; if (outsVec !== 11'b0) begin mismatched++; $display("[TB] FAIL reset outs: got %b want %b", outsVec, 11'b0); end
        compared++; if (retired !== '0) begin mismatched++; $display("[TB] FAIL reset retired: got %0d want 0", retired); end
        rst = 1'b0;
        push(0, 4'h0, 0, 0, IDLE, outsFor(IDLE, 0, 0, 0, 0, 0));
        push(0, 4'h0, 0, 0, IDLE, outsFor(IDLE, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL idle state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL idle outs: got %b want %b", outsVec, cur.outs); end
        end
    endtask

    task automatic test_alu_reg();
        step_t cur;
        push(1, 4'b0001, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b0001, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b0001, 0, 0, EXEC,   outsFor(EXEC, 0, 0, 0, 0, 0));
        push(1, 4'b0001, 0, 0, WB,     outsFor(WB, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b0001, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL alu state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL alu outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL alu retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_imm_cpi();
        step_t cur;
        push(1, 4'b0110, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b0110, 0, 0, EXEC,   outsFor(EXEC, 1, 0, 0, 0, 0));
        push(1, 4'b0110, 0, 0, WB,     outsFor(WB, 1, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b1010, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1010, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1010, 0, 0, EXEC,   outsFor(EXEC, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b1010, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL imm_cpi state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL imm_cpi outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL imm_cpi retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_mem_access();
        step_t cur;
        push(1, 4'b1001, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) push(1, 4'b1001, 0, 0, MEM, outsFor(MEM, 0, 1, 0, 0, 0));
        push(1, 4'b1001, 1, 0, WB,     outsFor(WB, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b1011, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1011, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1011, 1, 0, MEM,    outsFor(MEM, 0, 0, 1, 0, 0));
        expRet++;
        push(1, 4'b1011, 1, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL mem state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL mem outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL mem retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_branch();
        step_t cur;
        push(1, 4'b1101, 0, 1, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1101, 0, 1, EXEC,   outsFor(EXEC, 0, 0, 0, 1, 0));
        expRet++;
        push(1, 4'b1101, 0, 1, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1101, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1101, 0, 0, EXEC,   outsFor(EXEC, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b1100, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1100, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1100, 0, 0, EXEC,   outsFor(EXEC, 0, 0, 0, 1, 0));
        expRet++;
        push(1, 4'b0000, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b0000, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b0000, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL branch state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL branch outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL branch retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_run_drop();
        step_t cur;
        push(1, 4'b0100, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b0100, 0, 0, EXEC,   outsFor(EXEC, 0, 0, 0, 0, 0));
        push(0, 4'b0100, 0, 0, WB,     outsFor(WB, 0, 0, 0, 0, 0));
        expRet++;
        push(0, 4'b0100, 0, 0, IDLE,   outsFor(IDLE, 0, 0, 0, 0, 0));
        push(0, 4'b0100, 0, 0, IDLE,   outsFor(IDLE, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL run_drop state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL run_drop outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL run_drop retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_mem_timeout();
        step_t cur;
        push(1, 4'b1011, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1011, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        for (int i = 0; i < MEM_TIMEOUT; i++) push(1, 4'b1011, 0, 0, MEM, outsFor(MEM, 0, 0, 1, 0, 0));
        push(1, 4'b1011, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 1));
        push(0, 4'b1011, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 1));
        push(1, 4'b1011, 1, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 1));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL timeout state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL timeout outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL timeout retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_halt();
        step_t cur;
        rst = 1'b1; run = 1'b0; memReady = 1'b0; zeroFlag = 1'b0;
        @(posedge clk); #1;
        expRet = '0;
        compared++; if (memErr !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_rst mem_err: got %b want 0", memErr); end
        compared++; if (retired !== expRet) begin mismatched++; $display("[TB] FAIL halt_rst retired: got %0d want %0d", retired, expRet); end
        rst = 1'b0;
        push(1, 4'b1111, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1111, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        expRet++;
        push(1, 4'b1111, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 0));
        push(0, 4'b1111, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 0));
        push(1, 4'b1111, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 0));
        push(0, 4'b1111, 0, 0, HALT,   outsFor(HALT, 0, 0, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL halt state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL halt outs: got %b want %b", outsVec, cur.outs); end
            compared++; if (retired !== cur.ret) begin mismatched++; $display("[TB] FAIL halt retired: got %0d want %0d", retired, cur.ret); end
        end
    endtask

    task automatic test_rst_in_mem();
        step_t cur;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expRet = '0;
        push(1, 4'b1001, 0, 0, FETCH,  outsFor(FETCH, 0, 0, 0, 0, 0));
        push(1, 4'b1001, 0, 0, DECODE, outsFor(DECODE, 0, 0, 0, 0, 0));
        push(1, 4'b1001, 0, 0, MEM,    outsFor(MEM, 0, 1, 0, 0, 0));
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            run = cur.run; instr = cur.ins; memReady = cur.mr; zeroFlag = cur.zf;
            @(posedge clk); #1;
            compared++; if (stateOut !== cur.st) begin mismatched++; $display("[TB] FAIL rst_mem state: got %0d want %0d", stateOut, cur.st); end
            compared++; if (outsVec !== cur.outs) begin mismatched++; $display("[TB] FAIL rst_mem outs: got %b want %b", outsVec, cur.outs); end
        end
        // Reset lands between edges; outputs must clear without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        compared++; if (stateOut !== IDLE) begin mismatched++; $display("[TB] FAIL async_rst state: got %0d want %0d", stateOut, IDLE); end
        compared++; if (outsVec !== 11'b0) begin mismatched++; $display("[TB] FAIL async_rst outs: got %b want %b", outsVec, 11'b0); end
        @(posedge clk); #1;
        compared++; if (outsVec !== 11'b0) begin mismatched++; $display("[TB] FAIL held_rst outs: got %b want %b", outsVec, 11'b0); end
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] fetch_exec_ctrl bench start");
        test_reset();
        test_alu_reg();
        test_imm_cpi();
        test_mem_access();
        test_branch();
        test_run_drop();
        test_mem_timeout();
        test_halt();
        test_rst_in_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
